scanchain_multi_writer: RTL and testbench
=========================================

SCANCHAIN_MULTI_WRITER -- requirements
Module: scanchain_multi_writer

Interface
REQ-001 SHALL have parameter NUM_CHAINS, default 4: number of independent scan chains, legal range 1..16.
REQ-002 SHALL have parameter ADDR_BITS, default 12: scan register address width.
REQ-003 SHALL have parameter PAYLOAD_BITS, default 160: scan payload width.
REQ-004 SHALL have parameter CLKS_PER_SCAN_CLK, default 100_000: clk cycles per scan_clk period; even, >= 4.
REQ-005 SHALL have ports: clk  input  1  sole clock; one clock; all logic on rising edge.
REQ-006 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have ports: data_valid  input  1 / data_ready  output  1 / data_in  input  8  command byte stream.
REQ-008 SHALL have ports: response_valid  output  1 / response_ready  input  1 / response_data  output  8  status byte stream.
REQ-009 SHALL have ports: scan_clk, scan_en, scan_in, scan_reset  output  NUM_CHAINS each  per-chain scan interface; bit i drives chain i.

Function
REQ-010 SHALL transfer a byte only when valid and ready are both high on a clk edge, on both streams.
REQ-011 SHALL use frame word W = {addr, payload}, width WB = ADDR_BITS+PAYLOAD_BITS, NB = ceil(WB/8) bytes.
REQ-012 SHALL treat the first frame byte as command: bit7 op (0 write, 1 reset); bits6:4 ignored; bits3:0 channel ch.
REQ-013 SHALL, for write op, accept NB further bytes, least-significant byte of W first; bits above WB-1 discarded.
REQ-014 SHALL implement states IDLE, RECV, SHIFT, LATCH, RSTPULSE, RESP; reset enters IDLE.
REQ-015 SHALL assert data_ready only in IDLE and RECV; data_ready low in SHIFT, LATCH, RSTPULSE, RESP.
REQ-016 SHALL transition IDLE->RECV on write command, IDLE->RSTPULSE on reset command with ch < NUM_CHAINS, IDLE->RESP on reset command with ch >= NUM_CHAINS.
REQ-017 SHALL transition RECV->SHIFT on the cycle after the last data byte if ch < NUM_CHAINS, else RECV->RESP (bytes consumed, no scan activity).
REQ-018 SHALL, in SHIFT, drive WB scan_clk periods on chain ch, scan_en[ch]=1, scan_in[ch] = W bit k in period k, k = 0..WB-1 (LSB first).
REQ-019 SHALL shape each scan_clk period as CLKS_PER_SCAN_CLK/2 cycles low then CLKS_PER_SCAN_CLK/2 cycles high; scan_in changes only on the first low cycle.
REQ-020 SHALL, in LATCH, drive one further scan_clk period on chain ch with scan_en[ch]=0, scan_in[ch]=0, then enter RESP.
REQ-021 SHALL, in RSTPULSE, hold scan_reset[ch]=1 for 2*CLKS_PER_SCAN_CLK cycles, scan_clk[ch]=0, then enter RESP.
REQ-022 SHALL, in RESP, hold response_valid=1 with response_data = 0xA0|ch on success or 0xE0|ch on invalid channel until accepted, then enter IDLE.
REQ-023 SHALL hold response_data stable while response_valid=1 and response_ready=0.
REQ-024 SHALL keep all scan outputs of chains other than ch at 0 at all times, and all chains at 0 in IDLE, RECV and RESP.
REQ-025 SHALL keep SHIFT duration exactly WB*CLKS_PER_SCAN_CLK cycles and LATCH exactly CLKS_PER_SCAN_CLK cycles.
REQ-026 SHALL NOT time out a partial frame; RECV waits indefinitely for remaining bytes.

Reset
REQ-027 SHALL, with reset high at a clk edge, set next cycle: state IDLE, data_ready=1, response_valid=0, response_data=0x00, all scan_clk/scan_en/scan_in/scan_reset=0.
REQ-028 SHALL discard any partial frame, shift or pending response on reset, including mid-SHIFT or mid-RSTPULSE.
REQ-029 SHALL ignore data_valid while reset is high.

Verification (NUM_CHAINS=4, ADDR_BITS=4, PAYLOAD_BITS=12, CLKS_PER_SCAN_CLK=4; WB=16, NB=2)
REQ-030 SHALL pass: bytes 0x02,0x34,0xA1 -> chain 2: 16 scan_clk periods, scan_en[2]=1, scan_in[2] = 0xA134 LSB first; 1 latch period; 68 cycles total; response 0xA2; chains 0,1,3 stay 0.
REQ-031 SHALL pass: bytes 0x05,0x00,0x00 -> no scan_clk edge on any chain; response 0xE5; data_ready returns high after response accepted.
REQ-032 SHALL pass: byte 0x81 -> scan_reset[1]=1 for exactly 8 cycles; no scan_clk edges; response 0xA1.
REQ-033 SHALL pass: response_ready held 0 for 20 cycles after 0xA2 ready -> response_valid and 0xA2 held stable, data_ready=0; accepted on first response_ready=1.
REQ-034 SHALL pass: reset asserted 1 cycle mid-SHIFT on chain 3 -> next cycle all scan outputs 0, data_ready=1, response_valid=0; subsequent 0x00,0xFF,0xFF frame produces response 0xA0.
REQ-035 SHALL pass: command 0x70 (reserved bits set, channel 0) followed by 0x01,0x00 -> treated as write to chain 0; response 0xA0.

Source files
------------

// File: rtl/scanchain_multi_writer.sv
`timescale 1ns/1ps
// Byte-stream driven writer for up to 16 scan chains: shifts {addr, payload}
// frames LSB first, latches them, or pulses a chain reset, then reports status.
module scanchain_multi_writer #(
    parameter int NUM_CHAINS        = 4,
    parameter int ADDR_BITS         = 12,
    parameter int PAYLOAD_BITS      = 160,
    parameter int CLKS_PER_SCAN_CLK = 100_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic [7:0]            data_in,
    output logic                  response_valid,
    input  logic                  response_ready,
    output logic [7:0]            response_data,
    output logic [NUM_CHAINS-1:0] scan_clk,
    output logic [NUM_CHAINS-1:0] scan_en,
    output logic [NUM_CHAINS-1:0] scan_in,
    output logic [NUM_CHAINS-1:0] scan_reset
);

    localparam int WB = ADDR_BITS + PAYLOAD_BITS;
    localparam int NB = (WB + 7) / 8;
    localparam int TW = $clog2(2 * CLKS_PER_SCAN_CLK);
    localparam int BW = $clog2(WB + 1);
    localparam int CW = $clog2(NB + 1);

    localparam logic [TW-1:0] TICK_HALF        = TW'(CLKS_PER_SCAN_CLK / 2);
    localparam logic [TW-1:0] TICK_PERIOD_LAST = TW'(CLKS_PER_SCAN_CLK - 1);
    localparam logic [TW-1:0] TICK_PULSE_LAST  = TW'(2 * CLKS_PER_SCAN_CLK - 1);
    localparam logic [BW-1:0] BIT_LAST         = BW'(WB - 1);
    localparam logic [CW-1:0] BYTE_LAST        = CW'(NB - 1);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        SHIFT,
        LATCH,
        RSTPULSE,
        RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        ch;
    logic              err;
    logic [NB*8-1:0]   word;
    logic [NB*8+7:0]   word_cat;
    logic [CW-1:0]     byte_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [TW-1:0]     tick;
    logic              ch_ok;
    logic              cmd_ch_ok;

    assign ch_ok     = ({1'b0, ch} < 5'(NUM_CHAINS));
    assign cmd_ch_ok = ({1'b0, data_in[3:0]} < 5'(NUM_CHAINS));
    // Bytes arrive LSB first, so each new byte enters at the top and the
    // whole frame slides down; after NB bytes the first byte sits at bit 0.
    assign word_cat  = {data_in, word};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        data_ready     = 1'b0;
        response_valid = 1'b0;
        response_data  = '0;
        case (state)
            IDLE: begin
                data_ready = 1'b1;
                if (data_valid) begin
                    if (data_in[7]) begin
                        state_nxt = cmd_ch_ok ? RSTPULSE : RESP;
                    end else begin
                        state_nxt = RECV;
                    end
                end
            end
            RECV: begin
                data_ready = 1'b1;
                if (data_valid && byte_cnt == BYTE_LAST) begin
                    state_nxt = ch_ok ? SHIFT : RESP;
                end
            end
            SHIFT: begin
                if (tick == TICK_PERIOD_LAST && bit_cnt == BIT_LAST) begin
                    state_nxt = LATCH;
                end
            end
            LATCH: begin
                if (tick == TICK_PERIOD_LAST) begin
                    state_nxt = RESP;
                end
            end
            RSTPULSE: begin
                if (tick == TICK_PULSE_LAST) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                response_valid = 1'b1;
                response_data  = {(err ? 4'hE : 4'hA), ch};
                if (response_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch       <= '0;
            err      <= 1'b0;
            word     <= '0;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            tick     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_valid) begin
                        ch       <= data_in[3:0];
                        err      <= data_in[7] && !cmd_ch_ok;
                        byte_cnt <= '0;
                        tick     <= '0;
                    end
                end
                RECV: begin
                    if (data_valid) begin
                        word     <= word_cat[NB*8+7:8];
                        byte_cnt <= byte_cnt + 1'b1;
                        err      <= !ch_ok;
                        bit_cnt  <= '0;
                        tick     <= '0;
                    end
                end
                SHIFT: begin
                    if (tick == TICK_PERIOD_LAST) begin
                        tick    <= '0;
                        word    <= word >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                LATCH, RSTPULSE: begin
                    tick <= tick + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Only the addressed chain is ever driven; SHIFT/LATCH/RSTPULSE are
    // reachable only with a valid channel, so the decode needs no extra guard.
    always_comb begin
        scan_clk   = '0;
        scan_en    = '0;
        scan_in    = '0;
        scan_reset = '0;
        for (int unsigned i = 0; i < NUM_CHAINS; i++) begin
            if (ch == 4'(i)) begin
                case (state)
                    SHIFT: begin
                        scan_clk[i] = (tick >= TICK_HALF);
                        scan_en[i]  = 1'b1;
                        scan_in[i]  = word[0];
                    end
                    LATCH: begin
                        scan_clk[i] = (tick >= TICK_HALF);
                    end
                    RSTPULSE: begin
                        scan_reset[i] = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scanchain_multi_writer.sv
`timescale 1ns/1ps
// Directed bench for scanchain_multi_writer with 4 chains, 16-bit frames and
// a 4-cycle scan clock; a negedge monitor accumulates per-chain scan activity.
module tb_scanchain_multi_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic [7:0] data_in = '0;
    logic       response_valid;
    logic       response_ready = 1'b0;
    logic [7:0] response_data;
    logic [3:0] scan_clk, scan_en, scan_in, scan_reset;

    int checks = 0;
    int failures = 0;

    scanchain_multi_writer #(
        .NUM_CHAINS(4),
        .ADDR_BITS(4),
        .PAYLOAD_BITS(12),
        .CLKS_PER_SCAN_CLK(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .data_in(data_in),
        .response_valid(response_valid),
        .response_ready(response_ready),
        .response_data(response_data),
        .scan_clk(scan_clk),
        .scan_en(scan_en),
        .scan_in(scan_in),
        .scan_reset(scan_reset)
    );

    always #5 clk = ~clk;

    logic [3:0]  prev_clk = '0;
    int          rise_cnt[4];
    int          en_cyc[4];
    int          act_cyc[4];
    int          rst_cyc[4];
    int          busy_cyc = 0;
    logic [15:0] cap[4];

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (scan_clk[i] && !prev_clk[i]) begin
                rise_cnt[i]++;
                if (scan_en[i]) cap[i] = {scan_in[i], cap[i][15:1]};
            end
            if (scan_en[i]) en_cyc[i]++;
            if (scan_reset[i]) rst_cyc[i]++;
            if (scan_clk[i] | scan_en[i] | scan_in[i] | scan_reset[i]) act_cyc[i]++;
        end
        prev_clk = scan_clk;
        if (!reset && !data_ready && !response_valid) busy_cyc++;
    end

    int s_rise[4];
    int s_en[4];
    int s_act[4];
    int s_rst[4];
    int s_busy;

    task automatic snap();
        s_rise = rise_cnt;
        s_en   = en_cyc;
        s_act  = act_cyc;
        s_rst  = rst_cyc;
        s_busy = busy_cyc;
    endtask

    function automatic int other_act(input int target);
        int sum = 0;
        for (int i = 0; i < 4; i++) if (i != target) sum += act_cyc[i] - s_act[i];
        return sum;
    endfunction

    function automatic int rise_total();
        int sum = 0;
        for (int i = 0; i < 4; i++) sum += rise_cnt[i] - s_rise[i];
        return sum;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        data_in    = b;
        data_valid = 1'b1;
        while (!data_ready && n < 300) begin
            tick();
            n++;
        end
        if (!data_ready) check("send_timeout", 32'(data_ready), 32'd1);
        tick();
        data_valid = 1'b0;
    endtask

    task automatic get_resp(input string tag, input logic [7:0] exp);
        int n = 0;
        response_ready = 1'b1;
        while (!response_valid && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(response_valid), 32'd1);
        check({tag, "_data"}, 32'(response_data), 32'(exp));
        tick();
        response_ready = 1'b0;
        check({tag, "_ready_back"}, 32'(data_ready), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) cap[i] = '0;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_ready", 32'(data_ready), 32'd1);
        check("rst_rvalid", 32'(response_valid), 32'd0);
        check("rst_rdata", 32'(response_data), 32'h00);
        check("rst_scan", 32'({scan_clk, scan_en, scan_in, scan_reset}), 32'h0);

        // Write 0xA134 to chain 2
        snap();
        send_byte(8'h02);
        send_byte(8'h34);
        send_byte(8'hA1);
        get_resp("wr2", 8'hA2);
        check("wr2_rises", 32'(rise_cnt[2] - s_rise[2]), 32'd17);
        check("wr2_en_cycles", 32'(en_cyc[2] - s_en[2]), 32'd64);
        check("wr2_capture", 32'(cap[2]), 32'hA134);
        check("wr2_busy", 32'(busy_cyc - s_busy), 32'd68);
        check("wr2_others", 32'(other_act(2)), 32'd0);
        check("wr2_no_rst", 32'(rst_cyc[2] - s_rst[2]), 32'd0);

        // Write to invalid chain 5
        snap();
        send_byte(8'h05);
        send_byte(8'h00);
        send_byte(8'h00);
        get_resp("wr5", 8'hE5);
        check("wr5_rises", 32'(rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3]
                               - s_rise[0] - s_rise[1] - s_rise[2] - s_rise[3]), 32'd0);
        check("wr5_busy", 32'(busy_cyc - s_busy), 32'd0);
        check("wr5_act", 32'(other_act(-1)), 32'd0);

        // Reset pulse on chain 1
        snap();
        send_byte(8'h81);
        get_resp("rp1", 8'hA1);
        check("rp1_pulse", 32'(rst_cyc[1] - s_rst[1]), 32'd8);
        check("rp1_rises", 32'(rise_total()), 32'd0);
        check("rp1_others", 32'(other_act(1)), 32'd0);
        check("rp1_busy", 32'(busy_cyc - s_busy), 32'd8);

        // Reset command to invalid chain 15
        snap();
        send_byte(8'h8F);
        get_resp("rp15", 8'hEF);
        check("rp15_act", 32'(other_act(-1)), 32'd0);
        check("rp15_busy", 32'(busy_cyc - s_busy), 32'd0);

        // Backpressured response
        send_byte(8'h02);
        send_byte(8'h34);
        send_byte(8'hA1);
        begin
            int n = 0;
            while (!response_valid && n < 300) begin
                tick();
                n++;
            end
        end
        for (int i = 0; i < 20; i++) begin
            check("bp_hold", 32'({response_valid, response_data, data_ready}), 32'({1'b1, 8'hA2, 1'b0}));
            tick();
        end
        response_ready = 1'b1;
        tick();
        response_ready = 1'b0;
        check("bp_accept_valid", 32'(response_valid), 32'd0);
        check("bp_accept_ready", 32'(data_ready), 32'd1);

        // Reset mid-SHIFT on chain 3, with a command byte offered during reset
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (20) tick();
        check("mid_in_shift", 32'(scan_en[3]), 32'd1);
        reset      = 1'b1;
        data_valid = 1'b1;
        data_in    = 8'h81;
        tick();
        reset      = 1'b0;
        data_valid = 1'b0;
        check("mid_scan", 32'({scan_clk, scan_en, scan_in, scan_reset}), 32'h0);
        check("mid_ready", 32'(data_ready), 32'd1);
        check("mid_rvalid", 32'(response_valid), 32'd0);
        tick();
        check("mid_idle_again", 32'({data_ready, response_valid, scan_reset}), 32'({1'b1, 1'b0, 4'h0}));
        snap();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'hFF);
        get_resp("post_rst", 8'hA0);
        check("post_rst_capture", 32'(cap[0]), 32'hFFFF);
        check("post_rst_rises", 32'(rise_cnt[0] - s_rise[0]), 32'd17);
        check("post_rst_others", 32'(other_act(0)), 32'd0);

        // Reserved command bits ignored
        snap();
        send_byte(8'h70);
        send_byte(8'h01);
        send_byte(8'h00);
        get_resp("resv", 8'hA0);
        check("resv_capture", 32'(cap[0]), 32'h0001);
        check("resv_en_cycles", 32'(en_cyc[0] - s_en[0]), 32'd64);
        check("resv_others", 32'(other_act(0)), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
